// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access stage.
//   - FSM state encodings (IDLE / REQ / RESP)
//   - funct3 access-size codes and the decoded size type
//   - byte-enable base patterns and lane/alignment helper functions
package mem_access_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Unlisted encodings (011, 110, 111) fall back to a full word access.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  // Halfwords ignore a[0] so an unaligned halfword still lands on a legal lane pair.
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return BE_BYTE << lo;
      SZ_H:    return BE_HALF << {lo[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/acknowledge bus.
//   req    master->slave  request, held until ack
//   we     master->slave  1 store, 0 load
//   addr   master->slave  word-aligned address
//   wdata  master->slave  store data replicated across lanes
//   be     master->slave  byte enables
//   ack    slave->master  access complete, rdata valid this cycle
//   rdata  slave->master  load word
interface mem_access_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: combinational load-data alignment.
//   rdata   in   XLEN  raw word from memory
//   lo      in   2     low address bits of the access
//   funct3  in   3     access size / signedness
//   data    out  XLEN  lane-selected, sign- or zero-extended result
module mem_access_load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lo, 3'b000} +: 8];
    half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    // funct3[2] marks the unsigned (BU/HU) variants.
    case (size_of(funct3))
      SZ_B:    data = funct3[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                                : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      SZ_H:    data = funct3[2] ? {{(XLEN-16){1'b0}}, half_sel}
                                : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage between execute and write-back.
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         op handshake from execute (ready only in IDLE)
//   alu_result, rs2_data, rd    address-or-result, store data, destination
//   reg_write, mem_read,
//   mem_write, funct3           op control
//   out_valid, out_we, out_rd,
//   out_data, fault             one-cycle write-back pulse
//   dmem                        data-memory bus (mem_access_if master)
// Build option: MISALIGN_TRAP_EN traps misaligned H/W accesses with fault
// instead of issuing them with the low address bits ignored.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  output logic             out_we,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_data,
  output logic             fault,
  mem_access_if.master     dmem
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_en_q, wb_en_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lo_q, lo_d;
  logic            fault_pend_q, fault_pend_d;
  logic            out_valid_q, out_valid_d;
  logic            out_we_q, out_we_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            fault_q, fault_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;

  logic            is_mem, is_store, misalign;
  size_e           in_size;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] load_data;

  assign is_mem   = mem_read | mem_write;
  assign is_store = mem_write & ~mem_read;   // read wins when both are set
  assign in_size  = size_of(funct3);

`ifdef MISALIGN_TRAP_EN
  assign misalign = misaligned(in_size, alu_result[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (in_size)
      SZ_B:    in_wdata = {(XLEN/8){rs2_data[7:0]}};
      SZ_H:    in_wdata = {(XLEN/16){rs2_data[15:0]}};
      default: in_wdata = rs2_data;
    endcase
  end

  mem_access_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem.rdata),
    .lo     (lo_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    wb_en_d      = wb_en_q;
    funct3_d     = funct3_q;
    lo_d         = lo_q;
    fault_pend_d = fault_pend_q;
    out_valid_d  = 1'b0;
    out_we_d     = 1'b0;
    fault_d      = 1'b0;
    out_rd_d     = out_rd_q;
    out_data_d   = out_data_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            out_we_d    = reg_write & (rd != 5'd0);
            out_rd_d    = rd;
            out_data_d  = alu_result;
          end else begin
            rd_d       = rd;
            wb_en_d    = reg_write & (rd != 5'd0) & ~is_store;
            funct3_d   = funct3;
            lo_d       = alu_result[1:0];
            cnt_d      = '0;
            out_data_d = '0;
            if (misalign) begin
              // Trapped access never touches memory; report it via RESP.
              state_d      = ST_RESP;
              fault_pend_d = 1'b1;
            end else begin
              state_d      = ST_REQ;
              fault_pend_d = 1'b0;
              req_d        = 1'b1;
              we_d         = is_store;
              addr_d       = {alu_result[XLEN-1:2], 2'b00};
              wdata_d      = in_wdata;
              be_d         = byte_en(in_size, alu_result[1:0]);
            end
          end
        end
      end
      ST_REQ: begin
        // An ack arriving on the final timeout cycle still completes normally.
        if (dmem.ack) begin
          state_d    = ST_RESP;
          req_d      = 1'b0;
          out_data_d = we_q ? '0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          req_d        = 1'b0;
          fault_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;   // bounded by CNT_LAST, so it cannot wrap
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        out_we_d    = wb_en_q & ~fault_pend_q;
        fault_d     = fault_pend_q;
        out_rd_d    = rd_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      funct3_q     <= '0;
      lo_q         <= '0;
      fault_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_we_q     <= 1'b0;
      out_rd_q     <= '0;
      out_data_q   <= '0;
      fault_q      <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wb_en_q      <= wb_en_d;
      funct3_q     <= funct3_d;
      lo_q         <= lo_d;
      fault_pend_q <= fault_pend_d;
      out_valid_q  <= out_valid_d;
      out_we_q     <= out_we_d;
      out_rd_q     <= out_rd_d;
      out_data_q   <= out_data_d;
      fault_q      <= fault_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_we     = out_we_q;
  assign out_rd     = out_rd_q;
  assign out_data   = out_data_q;
  assign fault      = fault_q;
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt;

  mem_access_if #(.XLEN(32)) dmem ();

  mem_access #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .rs2_data   (rs2_data),
    .rd         (rd),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .out_valid  (out_valid),
    .out_we     (out_we),
    .out_rd     (out_rd),
    .out_data   (out_data),
    .fault      (fault),
    .dmem       (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept edge, then withdraw it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       input logic rdb, input logic wrb, input logic rw, input logic [4:0] r);
    in_valid = 1'b1; alu_result = a; rs2_data = d; funct3 = f3;
    mem_read = rdb; mem_write = wrb; reg_write = rw; rd = r;
    step();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
  endtask

  // Wait ack_delay REQ cycles, ack with rdat, then advance through RESP.
  task automatic finish_mem(input int ack_delay, input logic [31:0] rdat);
    repeat (ack_delay) step();
    dmem.ack = 1'b1; dmem.rdata = rdat;
    step();
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; rs2_data = '0; rd = '0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    dmem.ack = 1'b0; dmem.rdata = '0;
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_req",       {31'd0, dmem.req},  32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_be",        {28'd0, dmem.be},   32'd0);
    check("rst_fault",     {31'd0, fault},     32'd0);
    rst_n = 1'b1;
    step();

    // Non-memory op, followed by a back-to-back second one
    in_valid = 1'b1; alu_result = 32'd25; rd = 5'd5; reg_write = 1'b1;
    step();
    check("nm_valid", {31'd0, out_valid}, 32'd1);
    check("nm_data",  out_data,           32'd25);
    check("nm_we",    {31'd0, out_we},    32'd1);
    check("nm_rd",    {27'd0, out_rd},    32'd5);
    alu_result = 32'd77; rd = 5'd0;
    step();
    in_valid = 1'b0; reg_write = 1'b0;
    check("nm2_data", out_data,           32'd77);
    check("nm2_we",   {31'd0, out_we},    32'd0);
    step();
    check("nm_pulse", {31'd0, out_valid}, 32'd0);

    // Ack outside REQ has no effect
    dmem.ack = 1'b1;
    step();
    dmem.ack = 1'b0;
    check("idle_ack_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ack_req",   {31'd0, dmem.req},  32'd0);

    // SW 0x100, ack on the third request cycle
    issue(32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    check("sw_req",   {31'd0, dmem.req}, 32'd1);
    check("sw_we",    {31'd0, dmem.we},  32'd1);
    check("sw_rdy",   {31'd0, in_ready}, 32'd0);
    check("sw_be",    {28'd0, dmem.be},  32'hF);
    check("sw_addr",  dmem.addr,         32'h100);
    check("sw_wdata", dmem.wdata,        32'hDEADBEEF);
    step(); step();
    check("sw_hold",  {31'd0, dmem.req}, 32'd1);
    dmem.ack = 1'b1;
    step();
    dmem.ack = 1'b0;
    check("sw_req_drop", {31'd0, dmem.req},  32'd0);
    check("sw_resp_val", {31'd0, out_valid}, 32'd0);
    step();
    check("sw_valid", {31'd0, out_valid}, 32'd1);
    check("sw_out_we", {31'd0, out_we},   32'd0);
    check("sw_fault", {31'd0, fault},     32'd0);
    check("sw_rdy_back", {31'd0, in_ready}, 32'd1);

    // SB 0x103
    issue(32'h103, 32'h000000A5, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
    check("sb_be",    {28'd0, dmem.be}, 32'h8);
    check("sb_wdata", dmem.wdata,       32'hA5A5A5A5);
    check("sb_addr",  dmem.addr,        32'h100);
    finish_mem(0, 32'h0);
    check("sb_valid", {31'd0, out_valid}, 32'd1);

    // LB 0x103 -> sign-extended top byte
    issue(32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7);
    check("lb_we_bus", {31'd0, dmem.we}, 32'd0);
    check("lb_be",     {28'd0, dmem.be}, 32'h8);
    finish_mem(1, 32'hA5000000);
    check("lb_valid", {31'd0, out_valid}, 32'd1);
    check("lb_data",  out_data,           32'hFFFFFFA5);
    check("lb_we",    {31'd0, out_we},    32'd1);
    check("lb_rd",    {27'd0, out_rd},    32'd7);

    // LHU / LH 0x102
    issue(32'h102, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd3);
    check("lhu_be", {28'd0, dmem.be}, 32'hC);
    finish_mem(0, 32'h80011234);
    check("lhu_data", out_data,        32'h00008001);
    check("lhu_we",   {31'd0, out_we}, 32'd1);
    issue(32'h102, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd0);
    finish_mem(0, 32'h80011234);
    check("lh_data", out_data,           32'hFFFF8001);
    check("lh_we",   {31'd0, out_we},    32'd0);
    check("lh_valid", {31'd0, out_valid}, 32'd1);

    // Load with both read and write set behaves as a load (HU, lane 0)
    issue(32'h200, 32'h0, 3'b101, 1'b1, 1'b1, 1'b1, 5'd2);
    check("rw_we_bus", {31'd0, dmem.we}, 32'd0);
    finish_mem(0, 32'h1234ABCD);
    check("rw_data", out_data,        32'h0000ABCD);
    check("rw_we",   {31'd0, out_we}, 32'd1);

    // No ack: request held exactly 15 cycles then fault
    issue(32'h200, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4);
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      if (dmem.req) req_cnt++;
      step();
    end
    check("to_req_cycles", req_cnt,              32'd15);
    check("to_valid",      {31'd0, out_valid},   32'd1);
    check("to_fault",      {31'd0, fault},       32'd1);
    check("to_we",         {31'd0, out_we},      32'd0);
    check("to_rdy",        {31'd0, in_ready},    32'd1);
    step();
    check("to_fault_pulse", {31'd0, fault},      32'd0);

    // Ack on the last allowed cycle beats the timeout
    issue(32'h300, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9);
    finish_mem(14, 32'h12345678);
    check("last_ack_fault", {31'd0, fault},   32'd0);
    check("last_ack_data",  out_data,         32'h12345678);
    check("last_ack_we",    {31'd0, out_we},  32'd1);

    // Reset during REQ
    issue(32'h400, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd1);
    check("rr_req_on", {31'd0, dmem.req}, 32'd1);
    rst_n = 1'b0;
    step();
    check("rr_req_off", {31'd0, dmem.req},  32'd0);
    check("rr_valid",   {31'd0, out_valid}, 32'd0);
    check("rr_rdy",     {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;
    step();

    // Misaligned word at 0x102
`ifdef MISALIGN_TRAP_EN
    issue(32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd6);
    check("ma_no_req", {31'd0, dmem.req}, 32'd0);
    check("ma_rdy",    {31'd0, in_ready}, 32'd0);
    step();
    check("ma_valid", {31'd0, out_valid}, 32'd1);
    check("ma_fault", {31'd0, fault},     32'd1);
    check("ma_we",    {31'd0, out_we},    32'd0);
`else
    issue(32'h102, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd6);
    check("ma_req",  {31'd0, dmem.req}, 32'd1);
    check("ma_be",   {28'd0, dmem.be},  32'hF);
    check("ma_addr", dmem.addr,         32'h100);
    finish_mem(0, 32'hCAFEF00D);
    check("ma_data",  out_data,        32'hCAFEF00D);
    check("ma_fault", {31'd0, fault},  32'd0);
    check("ma_we",    {31'd0, out_we}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
